regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised successor to the integer register file. It provides NUM_READ synchronous read ports, one write port, and a hardwired-zero x0. It also holds a per-register busy scoreboard for outstanding long-latency writebacks, and a sequential clear engine that zeroes the array on request. It sits between decode (read/issue) and writeback in the core pipeline.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
NUM_READ, 2, number of read ports (1..4)
AW, $clog2(NUM_REGS), select width (derived, not overridable)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
write_enable  in  1  writeback strobe
write_select  in  AW  writeback destination
data_in  in  XLEN  writeback data
read_select  in  NUM_READ*AW  packed read selects, port p at [p*AW +: AW]
read_data  out  NUM_READ*XLEN  packed registered read data
read_busy  out  NUM_READ  registered scoreboard bit of each selected register
busy_set_en  in  1  mark a register pending (load/long op issued)
busy_set_select  in  AW  register to mark pending
clear_req  in  1  start a sequential array clear
clear_busy  out  1  high while the clear engine runs

Behaviour:
- Reset (async, reset_n=0): all registers = 0, all busy bits = 0, read_data = 0, read_busy = 0, FSM = IDLE, clear_busy = 0, clear index = 0.
- Read latency is 1 cycle. At each rising edge, read_data[p] <= reg[read_select[p]] and read_busy[p] <= busy[read_select[p]]. Both use pre-edge array state (the bypass exception is under Optional Feature).
- Register 0 always reads 0 with busy 0. Writes to 0 and busy_set to 0 are silently dropped.
- Write: if write_enable and write_select != 0 and FSM == IDLE, then reg[write_select] <= data_in and busy[write_select] <= 0.
- Scoreboard: if busy_set_en and busy_set_select != 0 and FSM == IDLE, then busy[busy_set_select] <= 1.
  - A write and a busy_set to the same register in the same cycle: the data is written and busy ends at 1 (set wins).
  - Different registers in the same cycle: both take effect.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req. At this edge all busy bits <= 0 and index <= 0. clear_busy rises the next cycle.
  - In CLEAR, each cycle reg[index] <= 0 and index <= index + 1. After writing index NUM_REGS-1, FSM returns to IDLE. CLEAR lasts exactly NUM_REGS cycles.
  - In CLEAR, write_enable, busy_set_en and clear_req are ignored. Reads still operate normally and return current array contents.
- Reset asserted mid-CLEAR returns everything to reset state immediately. No resume.
- Index wraps only by FSM exit, never arithmetically.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If write_enable is accepted (IDLE, write_select != 0) and read_select[p] == write_select, then read_data[p] <= data_in.
  - read_busy[p] takes the post-update busy value: 0, or 1 if a same-cycle busy_set targets the same register.
  - busy_set alone to the selected register also forwards busy=1.
- Undefined: reads always return pre-edge state. A same-cycle write becomes visible one read later.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (RF_IDLE, RF_CLEAR)
  - default XLEN/NUM_REGS constants
  - a localparam function for the select width.
- One natural sub-module: regfile_read_port. It handles a single port's select decode, the zero-register force, the optional bypass mux and the output flops. It is instantiated NUM_READ times in a generate loop.

Test Plan:
- Reset then read x5 on port 0 -> read_data = 0 and read_busy = 0 one cycle later. Write 0xDEADBEEF to x0, read x0 -> 0.
- Write 0x12345678 to x7, next cycle read x7 on both ports -> both ports return 0x12345678 one cycle after the read select.
- busy_set x9, then read x9 -> read_busy = 1. Write x9 = 0xA5 -> next read gives busy 0, data 0xA5. Same-cycle set+write on x9 -> busy stays 1, data updated.
- With REGFILE_BYPASS_EN: write x3 = 0x55 while reading x3 -> read_data = 0x55 on the next edge. Without the macro, that read returns the old value 0.
- Fill x1..x31 with nonzero values, pulse clear_req -> clear_busy high for 32 cycles. A write to x4 during CLEAR is dropped, busy bits are 0, and afterwards every register reads 0.
- Drop reset_n mid-CLEAR (cycle 10) -> clear_busy = 0 and outputs = 0 immediately. After release the FSM is in IDLE and a write is accepted.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
//   rf_state_e   : clear-engine FSM state
//   RF_XLEN      : default register width
//   RF_NUM_REGS  : default register count
//   rf_sel_width : register select width for a given register count
package regfile_pkg;

    localparam int unsigned RF_XLEN     = 32;
    localparam int unsigned RF_NUM_REGS = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Select width; a single-register file still needs a one-bit select.
    function automatic int unsigned rf_sel_width(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp.
// Build option: REGFILE_BYPASS_EN forwards a same-cycle accepted write
// (and busy_set) to this port instead of returning pre-edge state.
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   rd_sel              : register select
//   regs, busy          : current array and scoreboard contents
//   wr_accept/sel/data  : accepted writeback this cycle (bypass source)
//   bs_accept/sel       : accepted busy_set this cycle (bypass source)
//   rd_data, rd_busy    : registered read results (1-cycle latency)
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = RF_XLEN,
    parameter  int unsigned NUM_REGS = RF_NUM_REGS,
    localparam int unsigned AW       = rf_sel_width(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [AW-1:0]       rd_sel,
    input  logic [XLEN-1:0]     regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic                wr_accept,
    input  logic [AW-1:0]       wr_sel,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                bs_accept,
    input  logic [AW-1:0]       bs_sel,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_busy
);

    logic [XLEN-1:0] rd_data_d, rd_data_q;
    logic            rd_busy_d, rd_busy_q;

    // Select decode, optional forwarding, then the x0 force (always last).
    always_comb begin
        rd_data_d = regs[rd_sel];
        rd_busy_d = busy[rd_sel];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (wr_sel == rd_sel)) begin
            rd_data_d = wr_data;
            rd_busy_d = 1'b0;
        end
        // A same-cycle busy_set wins over the write's busy clear.
        if (bs_accept && (bs_sel == rd_sel)) begin
            rd_busy_d = 1'b1;
        end
`endif
        if (rd_sel == '0) begin
            rd_data_d = '0;
            rd_busy_d = 1'b0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_accept, wr_sel, wr_data, bs_accept, bs_sel};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and a sequential
// clear engine. x0 is hardwired to zero.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   write_enable/select, data_in   : writeback port
//   read_select                    : packed selects, port p at [p*AW +: AW]
//   read_data, read_busy           : packed registered read results
//   busy_set_en, busy_set_select   : mark a register pending
//   clear_req, clear_busy          : start / status of the array clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = RF_XLEN,
    parameter  int unsigned NUM_REGS = RF_NUM_REGS,
    parameter  int unsigned NUM_READ = 2,
    localparam int unsigned AW       = rf_sel_width(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     write_enable,
    input  logic [AW-1:0]            write_select,
    input  logic [XLEN-1:0]          data_in,
    input  logic [NUM_READ*AW-1:0]   read_select,
    output logic [NUM_READ*XLEN-1:0] read_data,
    output logic [NUM_READ-1:0]      read_busy,
    input  logic                     busy_set_en,
    input  logic [AW-1:0]            busy_set_select,
    input  logic                     clear_req,
    output logic                     clear_busy
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    rf_state_e           state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                clear_busy_q, clear_busy_d;

    logic idle;
    logic wr_accept;
    logic bs_accept;
    logic clr_start;

    assign idle      = (state_q == RF_IDLE);
    assign wr_accept = idle && write_enable && (write_select != '0);
    assign clr_start = idle && clear_req;
    // A busy_set coinciding with clear start is wiped by the clear anyway;
    // excluding it keeps forwarded busy consistent with the array.
    assign bs_accept = idle && busy_set_en && (busy_set_select != '0) && !clear_req;

    // Array, scoreboard and clear-engine next state.
    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        state_d      = state_q;
        idx_d        = idx_q;
        clear_busy_d = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (wr_accept) begin
                    regs_d[write_select] = data_in;
                    busy_d[write_select] = 1'b0;
                end
                if (bs_accept) begin
                    busy_d[busy_set_select] = 1'b1;
                end
                if (clr_start) begin
                    busy_d  = '0;
                    idx_d   = '0;
                    state_d = RF_CLEAR;
                end
            end
            RF_CLEAR: begin
                regs_d[idx_q] = '0;
                if (idx_q == AW'(NUM_REGS - 1)) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: state_d = RF_IDLE;
        endcase
        clear_busy_d = (state_d == RF_CLEAR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            state_q      <= RF_IDLE;
            idx_q        <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    assign clear_busy = clear_busy_q;

    for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS)
        ) u_port (
            .clock     (clock),
            .reset_n   (reset_n),
            .rd_sel    (read_select[p*AW +: AW]),
            .regs      (regs_q),
            .busy      (busy_q),
            .wr_accept (wr_accept),
            .wr_sel    (write_select),
            .wr_data   (data_in),
            .bs_accept (bs_accept),
            .bs_sel    (busy_set_select),
            .rd_data   (read_data[p*XLEN +: XLEN]),
            .rd_busy   (read_busy[p])
        );
    end

endmodule
